bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, BRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 128, BRAM data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant before forced release.
REQ-004 SHALL use reset rst, asynchronous, active-high, and clock reg_clk.
REQ-005 reg_clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req0 / req1  in  1  access request from requester 0 (bulk transfer FSM) and requester 1 (register-bus debug path).
REQ-008 addr0 / addr1  in  ADDR_W  word address per beat.
REQ-009 we0 / we1  in  DATA_W/8  byte write enables; all-zero means read beat.
REQ-010 wdata0 / wdata1  in  DATA_W  write data per beat.
REQ-011 last0 / last1  in  1  marks final beat of a burst.
REQ-012 gnt0 / gnt1  out  1  registered grant; a beat occurs on any cycle with gntN & reqN.
REQ-013 rvalid0 / rvalid1  out  1  read data valid for requester N.
REQ-014 rdata  out  DATA_W  read data, shared, qualified by rvalid0/rvalid1.
REQ-015 bram_en / bram_we / bram_addr / bram_wrdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  registered BRAM port.
REQ-016 bram_rddata  in  DATA_W  BRAM read data, available one cycle after bram_en with bram_we==0.
REQ-017 busy  out  1  high while in GRANT0 or GRANT1; owner  out  1  last granted requester index.

Function
REQ-018 SHALL implement FSM states IDLE, GRANT0, GRANT1; gnt0 high only in GRANT0, gnt1 only in GRANT1.
REQ-019 IDLE: single requester N asserting reqN at cycle t -> GRANTN, gntN high from t+1.
REQ-020 IDLE, both requesting: grant the requester not equal to owner (round-robin); after reset owner=1, so requester 0 wins first.
REQ-021 Beat at cycle t: bram_en=1, bram_addr/bram_we/bram_wrdata = granted requester's inputs, visible at t+1; non-beat cycles drive bram_en=0, bram_we=0.
REQ-022 Read beat at t: rvalidN high at t+2 with rdata = bram_rddata; rvalid to the issuing requester regardless of later grant changes; one outstanding read per cycle, fully pipelined.
REQ-023 8-bit beat counter cleared on entering a GRANT state, incremented per beat.
REQ-024 Grant released after the beat with lastN=1, or the MAX_BURST-th beat, or any cycle in GRANTN with reqN=0.
REQ-025 On release, if the other requester has req high that cycle, transition directly GRANTN -> GRANT other (no IDLE cycle); else -> IDLE.
REQ-026 Forced release at MAX_BURST with only the same requester still requesting -> re-grant via IDLE (one-cycle gap, gnt low).
REQ-027 owner updates to N on every entry into GRANTN.
REQ-028 Write beats produce no rvalid; mixed read/write beats within one burst are allowed.
REQ-029 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 never high together.

Reset
REQ-030 rst SHALL force IDLE, gnt0=gnt1=0, bram_en=0, bram_we=0, bram_addr=0, bram_wrdata=0, rvalid0=rvalid1=0, rdata=0, busy=0, owner=1, counter=0.
REQ-031 rst mid-burst SHALL discard in-flight reads (no rvalid after deassertion); first grant after reset follows REQ-019/020.

Verification
REQ-032 req0 alone, 3 read beats addr 5,6,7, last0 on third -> gnt0 cycles 1-3, bram_addr 5,6,7 at cycles 2-4, rvalid0 cycles 3-5, gnt0 low cycle 4.
REQ-033 req0 and req1 together from reset -> GRANT0 first; after last0, GRANT1 next cycle with no IDLE gap; owner=1.
REQ-034 req0 held 20 beats, no last0, MAX_BURST=16, req1 high -> gnt0 drops after beat 16, gnt1 high next cycle.
REQ-035 Write beat we1=16'hFFFF addr 8'h66 data all-0xA5 -> bram_we=16'hFFFF, bram_addr=8'h66 one cycle later, no rvalid1.
REQ-036 rst asserted cycle after read beat -> outputs zero immediately, rvalid0 never asserted for that beat.
REQ-037 Read by requester 0 on its last beat, grant switches to 1 -> rvalid0 (not rvalid1) asserted two cycles after the beat.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port: bulk FSM (0) and debug path (1).
// Bursts of registered beats, round-robin on contention, two-cycle read return.
module bram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 16
) (
  input  logic                reg_clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W/8-1:0] we0,
  input  logic [DATA_W/8-1:0] we1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic                last0,
  input  logic                last1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wrdata,
  input  logic [DATA_W-1:0]   bram_rddata,
  output logic                busy,
  output logic                owner,
  output logic [1:0]          state_dbg
);

  // Handshake: a beat is any cycle with gntN & reqN; the requester must hold
  // addr/we/wdata/last valid for that cycle and no other acknowledgement exists.
  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                bram_en_q, bram_en_d;
  logic [BE_W-1:0]     bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_wrdata_q, bram_wrdata_d;
  logic [1:0]          rd_pend_q, rd_pend_d;
  logic [1:0]          rvalid_q, rvalid_d;

  logic                cur_req, cur_last, oth_req, beat;
  logic [ADDR_W-1:0]   cur_addr;
  logic [BE_W-1:0]     cur_we;
  logic [DATA_W-1:0]   cur_wdata;

  always_comb begin
    cur_req   = (state_q == GRANT1) ? req1   : req0;
    cur_last  = (state_q == GRANT1) ? last1  : last0;
    cur_addr  = (state_q == GRANT1) ? addr1  : addr0;
    cur_we    = (state_q == GRANT1) ? we1    : we0;
    cur_wdata = (state_q == GRANT1) ? wdata1 : wdata0;
    oth_req   = (state_q == GRANT1) ? req0   : req1;
    beat      = (state_q != IDLE) && cur_req;

    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    bram_en_d     = 1'b0;
    bram_we_d     = '0;
    bram_addr_d   = bram_addr_q;
    bram_wrdata_d = bram_wrdata_q;
    rd_pend_d     = 2'b00;
    rvalid_d      = rd_pend_q;

    if (beat) begin
      bram_en_d     = 1'b1;
      bram_we_d     = cur_we;
      bram_addr_d   = cur_addr;
      bram_wrdata_d = cur_wdata;
      cnt_d         = cnt_q + 8'd1;
      // Read return is tagged with the issuer so a later grant switch cannot steer it.
      if (cur_we == '0) rd_pend_d = (state_q == GRANT1) ? 2'b10 : 2'b01;
    end

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || owner_q)) begin
          state_d = GRANT0;
          owner_d = 1'b0;
          cnt_d   = 8'd0;
        end else if (req1) begin
          state_d = GRANT1;
          owner_d = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      GRANT0, GRANT1: begin
        if (!cur_req || cur_last || (cnt_q == BURST_LAST)) begin
          if (oth_req) begin
            state_d = (state_q == GRANT0) ? GRANT1 : GRANT0;
            owner_d = (state_q == GRANT0);
            cnt_d   = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b1;
      cnt_q         <= 8'd0;
      bram_en_q     <= 1'b0;
      bram_we_q     <= '0;
      bram_addr_q   <= '0;
      bram_wrdata_q <= '0;
      rd_pend_q     <= 2'b00;
      rvalid_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      bram_en_q     <= bram_en_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_wrdata_q <= bram_wrdata_d;
      rd_pend_q     <= rd_pend_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign gnt0        = (state_q == GRANT0);
  assign gnt1        = (state_q == GRANT1);
  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign state_dbg   = state_q;
  assign bram_en     = bram_en_q;
  assign bram_we     = bram_we_q;
  assign bram_addr   = bram_addr_q;
  assign bram_wrdata = bram_wrdata_q;
  assign rvalid0     = rvalid_q[0];
  assign rvalid1     = rvalid_q[1];
  // BRAM output is passed straight through while a return is valid, zero otherwise.
  assign rdata       = (|rvalid_q) ? bram_rddata : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed vector table, corner sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_bram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  localparam int MAXB = 16;

  // ---------------- clock / reset ----------------
  logic reg_clk = 1'b0;
  logic rst = 1'b0;
  always #5 reg_clk = ~reg_clk;

  logic          req0, req1, last0, last1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] we0, we1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, bram_en, busy, owner;
  logic [DW-1:0] rdata, bram_wrdata, bram_rddata;
  logic [BW-1:0] bram_we;
  logic [AW-1:0] bram_addr;
  logic [1:0]    state_dbg;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .reg_clk(reg_clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
    .last0(last0), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
    .bram_rddata(bram_rddata), .busy(busy), .owner(owner),
    .state_dbg(state_dbg)
  );

  typedef struct {
    logic          req0, req1, last0, last1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] we0, we1;
    logic [DW-1:0] wd0, wd1;
  } in_t;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_g: requester holding the grant (-1 none). Expected outputs for the
  // current cycle are kept in e_*; e_rv1 is the read return due next cycle.
  int            m_g, m_cnt, e_rv, e_rv1;
  logic          m_owner, e_en;
  logic [BW-1:0] e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic [DW-1:0] exp_q[$];   // read data expected on rdata, in return order

  task automatic model_reset();
    m_g = -1; m_cnt = 0; m_owner = 1'b1;
    e_rv = -1; e_rv1 = -1; e_en = 1'b0; e_we = '0; e_addr = '0; e_wd = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input in_t x);
    logic rq, lst, oreq;
    logic [AW-1:0] a;
    logic [BW-1:0] w;
    logic [DW-1:0] d;
    logic bt;
    rq   = (m_g == 1) ? x.req1  : x.req0;
    lst  = (m_g == 1) ? x.last1 : x.last0;
    oreq = (m_g == 1) ? x.req0  : x.req1;
    a    = (m_g == 1) ? x.addr1 : x.addr0;
    w    = (m_g == 1) ? x.we1   : x.we0;
    d    = (m_g == 1) ? x.wd1   : x.wd0;
    bt   = (m_g >= 0) && rq;
    e_rv  = e_rv1;
    e_rv1 = (bt && w == '0) ? m_g : -1;
    e_en  = bt;
    e_we  = bt ? w : '0;
    if (bt) begin e_addr = a; e_wd = d; end
    if (m_g >= 0) begin
      if (bt) m_cnt++;
      if (!rq || lst || m_cnt == MAXB) begin
        if (oreq) begin m_g = 1 - m_g; m_cnt = 0; m_owner = (m_g == 1); end
        else m_g = -1;
      end
    end else begin
      if (x.req0 && x.req1) m_g = m_owner ? 0 : 1;
      else if (x.req0) m_g = 0;
      else if (x.req1) m_g = 1;
      if (m_g >= 0) begin m_cnt = 0; m_owner = (m_g == 1); end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t x);
    req0 = x.req0; req1 = x.req1; last0 = x.last0; last1 = x.last1;
    addr0 = x.addr0; addr1 = x.addr1; we0 = x.we0; we1 = x.we1;
    wdata0 = x.wd0; wdata1 = x.wd1;
  endtask

  function automatic in_t idle_in();
    in_t x;
    x.req0 = 0; x.req1 = 0; x.last0 = 0; x.last1 = 0;
    x.addr0 = '0; x.addr1 = '0; x.we0 = '0; x.we1 = '0; x.wd0 = '0; x.wd1 = '0;
    return x;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive inputs, compare DUT against model, advance model.
  task automatic step(input in_t x);
    logic [DW-1:0] rd;
    @(posedge reg_clk);
    #1;
    drive(x);
    rd = rnd_data();
    bram_rddata = rd;
    if (e_rv >= 0) exp_q.push_back(rd);
    #1;
    chk("gnt0", gnt0, m_g == 0);
    chk("gnt1", gnt1, m_g == 1);
    chk("busy", busy, m_g >= 0);
    chk("owner", owner, m_owner);
    chk("bram_en", bram_en, e_en);
    chk("bram_we", bram_we, e_we);
    if (e_en) begin
      chk("bram_addr", bram_addr, e_addr);
      chk("bram_wrdata", bram_wrdata, e_wd);
    end
    chk("rvalid0", rvalid0, e_rv == 0);
    chk("rvalid1", rvalid1, e_rv == 1);
    if (e_rv >= 0) chk("rdata", rdata, exp_q.pop_front());
    else chk("rdata_idle", rdata, '0);
    model_step(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(idle_in());
    bram_rddata = rnd_data();
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_en", bram_en, 0);
    chk("rst_we", bram_we, '0);
    chk("rst_addr", bram_addr, '0);
    chk("rst_wrdata", bram_wrdata, '0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata", rdata, '0);
    chk("rst_state", state_dbg, 2'd0);
    repeat (2) @(posedge reg_clk);
    @(negedge reg_clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          req0, last0;
    logic [AW-1:0] addr0;
    logic          x_gnt0, x_en;
    logic [AW-1:0] x_addr;
    logic          x_rv0;
  } vec_t;

  vec_t vt[7];

  initial begin
    in_t x;
    int g0cnt;
    drive(idle_in());
    bram_rddata = '0;
    model_reset();
    #2;

    // Three-beat read burst from requester 0 at addresses 5,6,7.
    vt[0] = '{1, 0, 8'd5, 0, 0, 8'd0, 0};
    vt[1] = '{1, 0, 8'd5, 1, 0, 8'd0, 0};
    vt[2] = '{1, 0, 8'd6, 1, 1, 8'd5, 0};
    vt[3] = '{1, 1, 8'd7, 1, 1, 8'd6, 1};
    vt[4] = '{0, 0, 8'd0, 0, 1, 8'd7, 1};
    vt[5] = '{0, 0, 8'd0, 0, 0, 8'd0, 1};
    vt[6] = '{0, 0, 8'd0, 0, 0, 8'd0, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      x = idle_in();
      x.req0 = vt[i].req0; x.last0 = vt[i].last0; x.addr0 = vt[i].addr0;
      step(x);
      chk($sformatf("vec%0d_gnt0", i), gnt0, vt[i].x_gnt0);
      chk($sformatf("vec%0d_en", i), bram_en, vt[i].x_en);
      if (vt[i].x_en) chk($sformatf("vec%0d_addr", i), bram_addr, vt[i].x_addr);
      chk($sformatf("vec%0d_rv0", i), rvalid0, vt[i].x_rv0);
    end

    // Contention from reset: 0 first, then 1 with no idle gap.
    do_reset();
    x = idle_in(); x.req0 = 1; x.req1 = 1;
    step(x);
    step(x);
    chk("rr_first_gnt0", gnt0, 1);
    x.last0 = 1;
    step(x);
    x.req0 = 0; x.last0 = 0; x.last1 = 1;
    step(x);
    chk("rr_switch_gnt1", gnt1, 1);
    chk("rr_owner", owner, 1);
    step(idle_in());
    step(idle_in());

    // Burst cap: requester 0 never signals last while 1 waits.
    do_reset();
    x = idle_in(); x.req0 = 1; x.req1 = 1;
    g0cnt = 0;
    for (int c = 0; c < 18; c++) begin
      x.addr0 = AW'(c);
      step(x);
      if (gnt0) g0cnt++;
    end
    chk("cap_beats", g0cnt, MAXB);
    chk("cap_gnt1", gnt1, 1);
    chk("cap_gnt0_low", gnt0, 0);
    repeat (3) step(idle_in());

    // Full-width write by requester 1.
    do_reset();
    x = idle_in(); x.req1 = 1; x.last1 = 1; x.addr1 = 8'h66; x.we1 = 16'hFFFF;
    x.wd1 = {16{8'hA5}};
    step(x);
    step(x);
    step(idle_in());
    chk("wr_we", bram_we, 16'hFFFF);
    chk("wr_addr", bram_addr, 8'h66);
    chk("wr_data", bram_wrdata, {16{8'hA5}});
    step(idle_in());
    chk("wr_no_rvalid1", rvalid1, 0);
    step(idle_in());

    // Reset the cycle after a read beat: that read must never return.
    do_reset();
    x = idle_in(); x.req0 = 1; x.last0 = 1; x.addr0 = 8'h21;
    step(x);
    step(x);
    @(posedge reg_clk);
    #1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(idle_in());
      chk("rst_drop_rv0", rvalid0, 0);
    end

    // Read on the final beat of 0, grant moves to 1: return goes to 0.
    do_reset();
    x = idle_in(); x.req0 = 1; x.req1 = 1; x.addr0 = 8'h03; x.we1 = '1;
    step(x);
    x.last0 = 1;
    step(x);
    x.req0 = 0; x.last0 = 0;
    step(x);
    chk("sw_gnt1", gnt1, 1);
    x.last1 = 1;
    step(x);
    chk("sw_rvalid0", rvalid0, 1);
    chk("sw_rvalid1", rvalid1, 0);
    step(idle_in());
    step(idle_in());

    // Randomized traffic against the model.
    do_reset();
    begin
      logic a0, a1;
      a0 = 0; a1 = 0;
      for (int c = 0; c < 1500; c++) begin
        x = idle_in();
        if (a0) a0 = ($urandom_range(0, 9) != 0); else a0 = ($urandom_range(0, 2) == 0);
        if (a1) a1 = ($urandom_range(0, 9) != 0); else a1 = ($urandom_range(0, 3) == 0);
        x.req0 = a0; x.req1 = a1;
        x.last0 = ($urandom_range(0, 9) == 0);
        x.last1 = ($urandom_range(0, 5) == 0);
        x.addr0 = AW'($urandom); x.addr1 = AW'($urandom);
        x.we0 = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        x.we1 = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        x.wd0 = rnd_data(); x.wd1 = rnd_data();
        step(x);
      end
    end
    repeat (3) step(idle_in());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
